// File: rtl/types_pkg.sv
// types_pkg: shared RV32I core types (opcodes, ALU ops, imm formats)
// plus multicycle sequencer states, datapath selects and decode bundle
package types_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_STORE  = 7'b0100011,
    OP_R      = 7'b0110011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111
  } opcode;

  typedef enum logic [2:0] {
    SUM_OP = 3'd0,
    SUB_OP = 3'd1,
    AND_OP = 3'd2,
    OR_OP  = 3'd3,
    XOR_OP = 3'd4,
    SLL_OP = 3'd5,
    SRL_OP = 3'd6,
    SLT_OP = 3'd7
  } alu_ctrl;

  typedef enum logic [1:0] {
    Imm    = 2'd0,
    Store  = 2'd1,
    Branch = 2'd2,
    Jump   = 2'd3
  } instr_format;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } mcu_state;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10
  } alu_src_a_t;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } alu_src_b_t;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00,
    RES_MEM    = 2'b01,
    RES_ALU    = 2'b10
  } result_src_t;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [6:0] F7_0   = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  // alt: sub for R, slli for I-ALU, bne for branches
  typedef struct packed {
    mcu_state    next;
    instr_format imm;
    logic        alt;
    logic        store;
  } dec_t;

endpackage

// File: rtl/mcu_decode.sv
// mcu_decode: legality check and DECODE next-state from the IR
// in: instr[31:0]  out: dec (next state, imm format, variant, store)
module mcu_decode
  import types_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_ld;
  logic       is_st;
  logic       is_r;
  logic       is_i;
  logic       is_b;
  logic       is_j;
  logic       unused_fields;

  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];

  // register/immediate fields belong to the datapath
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  assign is_ld = (op == OP_LOAD);
  assign is_st = (op == OP_STORE);
  assign is_r  = (op == OP_R);
  assign is_i  = (op == OP_IMM);
  assign is_b  = (op == OP_BRANCH);
  assign is_j  = (op == OP_JAL);

  always_comb begin
    dec.next  = TRAP;
    dec.imm   = Imm;
    dec.alt   = 1'b0;
    dec.store = 1'b0;
    unique case (1'b1)
      is_ld: begin
        if (f3 == F3_W) dec.next = MEMADR;
      end
      is_st: begin
        dec.imm   = Store;
        dec.store = 1'b1;
        if (f3 == F3_W) dec.next = MEMADR;
      end
      is_r: begin
        dec.alt = f7[5];
        if (f3 == F3_ADD &&
            (f7 == F7_0 || f7 == F7_SUB))
          dec.next = EXEC_R;
      end
      is_i: begin
        dec.alt = (f3 == F3_SLL);
        if (f3 == F3_ADD ||
            (f3 == F3_SLL && f7 == F7_0))
          dec.next = EXEC_I;
      end
      is_b: begin
        dec.imm = Branch;
        dec.alt = f3[0];
        if (f3[2:1] == 2'b00) dec.next = BRANCH;
      end
      is_j: begin
        dec.imm  = Jump;
        dec.next = JAL;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multi-cycle sequencer (FSM + output decode)
// ports: clk, rst(async low), instr, EQ, mem_ready -> mem/datapath ctl;
// MCU_PERF_CNT_EN adds cycle_cnt/instret_cnt
module multicycle_ctrl
  import types_pkg::*;
#(
  parameter bit RESET_STATE_TRAP = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        EQ,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic [1:0]  ALUsrcA,
  output logic [1:0]  ALUsrcB,
  output alu_ctrl     ALUctrl,
  output instr_format ImmSrc,
  output logic [1:0]  ResultSrc,
  output logic        instr_done,
  output logic        illegal
`ifdef MCU_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  mcu_state    state;
  dec_t        dec;
  alu_src_a_t  sa;
  alu_src_b_t  sb;
  result_src_t rs;
  alu_ctrl     op;
  instr_format imm;
  logic        req;
  logic        mw;
  logic        adr;
  logic        irw;
  logic        pcw;
  logic        rw;
  logic        done;
  logic        ill;

  mcu_decode u_dec (
    .instr (instr),
    .dec   (dec)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if (RESET_STATE_TRAP) state <= TRAP;
      else                  state <= FETCH;
    end else begin
      unique case (state)
        FETCH:    if (mem_ready) state <= DECODE;
        DECODE:   state <= dec.next;
        MEMADR:   state <= dec.store ? MEMWRITE
                                     : MEMREAD;
        MEMREAD:  if (mem_ready) state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: if (mem_ready) state <= FETCH;
        EXEC_R:   state <= ALUWB;
        EXEC_I:   state <= ALUWB;
        ALUWB:    state <= FETCH;
        BRANCH:   state <= FETCH;
        JAL:      state <= ALUWB;
        TRAP:     state <= TRAP;
        default:  state <= TRAP;
      endcase
    end
  end

  always_comb begin
    req  = 1'b0;
    mw   = 1'b0;
    adr  = 1'b0;
    irw  = 1'b0;
    pcw  = 1'b0;
    rw   = 1'b0;
    done = 1'b0;
    ill  = 1'b0;
    sa   = SRCA_PC;
    sb   = SRCB_RS2;
    op   = SUM_OP;
    rs   = RES_ALUOUT;
    imm  = Imm;
    unique case (state)
      FETCH: begin
        req = 1'b1;
        sb  = SRCB_FOUR;
        rs  = RES_ALU;
        irw = mem_ready;
        pcw = mem_ready;
      end
      DECODE: begin
        sa  = SRCA_OLDPC;
        sb  = SRCB_IMM;
        imm = dec.imm;
      end
      MEMADR: begin
        sa  = SRCA_RS1;
        sb  = SRCB_IMM;
        imm = dec.imm;
      end
      MEMREAD: begin
        req = 1'b1;
        adr = 1'b1;
      end
      MEMWB: begin
        rw   = 1'b1;
        rs   = RES_MEM;
        done = 1'b1;
      end
      MEMWRITE: begin
        req  = 1'b1;
        mw   = 1'b1;
        adr  = 1'b1;
        done = mem_ready;
      end
      EXEC_R: begin
        sa = SRCA_RS1;
        if (dec.alt) op = SUB_OP;
      end
      EXEC_I: begin
        sa = SRCA_RS1;
        sb = SRCB_IMM;
        if (dec.alt) op = SLL_OP;
      end
      ALUWB: begin
        rw   = 1'b1;
        done = 1'b1;
      end
      BRANCH: begin
        sa   = SRCA_RS1;
        op   = SUB_OP;
        // bne inverts the taken sense
        pcw  = EQ ^ dec.alt;
        done = 1'b1;
      end
      JAL: begin
        pcw = 1'b1;
        sa  = SRCA_OLDPC;
        sb  = SRCB_FOUR;
      end
      TRAP: ill = 1'b1;
      default: ;
    endcase
  end

  // reset forces everything idle, also cancels an in-flight request
  assign mem_req    = rst & req;
  assign MemWrite   = rst & mw;
  assign AdrSrc     = rst & adr;
  assign IRWrite    = rst & irw;
  assign PCWrite    = rst & pcw;
  assign RegWrite   = rst & rw;
  assign instr_done = rst & done;
  assign illegal    = rst & ill;
  assign ALUsrcA    = rst ? sa : SRCA_PC;
  assign ALUsrcB    = rst ? sb : SRCB_RS2;
  assign ResultSrc  = rst ? rs : RES_ALUOUT;
  assign ALUctrl    = rst ? op : SUM_OP;
  assign ImmSrc     = rst ? imm : Imm;

`ifdef MCU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != TRAP)
        cycle_cnt <= cycle_cnt + 32'd1;
      if (done)
        instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized per-cycle check of multicycle_ctrl
// against an instruction-level phase model
module tb_multicycle_ctrl;
  import types_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        EQ;
  logic        mem_ready;
  logic        mem_req;
  logic        MemWrite;
  logic        AdrSrc;
  logic        IRWrite;
  logic        PCWrite;
  logic        RegWrite;
  logic [1:0]  ALUsrcA;
  logic [1:0]  ALUsrcB;
  alu_ctrl     ALUctrl;
  instr_format ImmSrc;
  logic [1:0]  ResultSrc;
  logic        instr_done;
  logic        illegal;
`ifdef MCU_PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
`endif

  multicycle_ctrl #(.RESET_STATE_TRAP(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .EQ         (EQ),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .MemWrite   (MemWrite),
    .AdrSrc     (AdrSrc),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .ALUsrcA    (ALUsrcA),
    .ALUsrcB    (ALUsrcB),
    .ALUctrl    (ALUctrl),
    .ImmSrc     (ImmSrc),
    .ResultSrc  (ResultSrc),
    .instr_done (instr_done),
    .illegal    (illegal)
`ifdef MCU_PERF_CNT_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {
    K_LW, K_SW, K_ADD, K_SUB, K_ADDI,
    K_SLLI, K_BEQ, K_BNE, K_JAL, K_ILL
  } kind_t;

  typedef struct {
    bit       fetch;
    bit       rdy;
    bit       eq;
    bit       req, mw, adr, irw, pcw, rw;
    bit       done, ill;
    bit       alu_chk;
    bit [1:0] a, b;
    bit [2:0] op;
    bit       res_chk;
    bit [1:0] res;
    bit       imm_chk;
    bit [1:0] imm;
  } cyc_t;

  cyc_t        q[$];
  int          vectors;
  int          miscompares;
  logic [31:0] ir_prev;
  int unsigned exp_cyc;
  int unsigned exp_ret;

  function automatic kind_t classify(logic [31:0] i);
    logic [6:0] o  = i[6:0];
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    if (o == 7'h03 && f3 == 3'd2) return K_LW;
    if (o == 7'h23 && f3 == 3'd2) return K_SW;
    if (o == 7'h33 && f3 == 3'd0 && f7 == 7'h00) return K_ADD;
    if (o == 7'h33 && f3 == 3'd0 && f7 == 7'h20) return K_SUB;
    if (o == 7'h13 && f3 == 3'd0) return K_ADDI;
    if (o == 7'h13 && f3 == 3'd1 && f7 == 7'h00) return K_SLLI;
    if (o == 7'h63 && f3 == 3'd0) return K_BEQ;
    if (o == 7'h63 && f3 == 3'd1) return K_BNE;
    if (o == 7'h6f) return K_JAL;
    return K_ILL;
  endfunction

  function automatic logic [31:0] gen(kind_t k);
    logic [4:0]  rd = 5'($urandom);
    logic [4:0]  r1 = 5'($urandom);
    logic [4:0]  r2 = 5'($urandom);
    logic [11:0] im = 12'($urandom);
    case (k)
      K_LW:   return {im, r1, 3'b010, rd, 7'h03};
      K_SW:   return {im[11:5], r2, r1, 3'b010, im[4:0], 7'h23};
      K_ADD:  return {7'h00, r2, r1, 3'b000, rd, 7'h33};
      K_SUB:  return {7'h20, r2, r1, 3'b000, rd, 7'h33};
      K_ADDI: return {im, r1, 3'b000, rd, 7'h13};
      K_SLLI: return {7'h00, r2, r1, 3'b001, rd, 7'h13};
      K_BEQ:  return {im[11:5], r2, r1, 3'b000, im[4:0], 7'h63};
      K_BNE:  return {im[11:5], r2, r1, 3'b001, im[4:0], 7'h63};
      K_JAL:  return {im, im[7:0], rd, 7'h6f};
      default: begin
        case ($urandom_range(0, 5))
          0: return {im, im[7:0], rd, 7'h37};
          1: return {im, r1, 3'b000, rd, 7'h03};
          2: return {7'h01, r2, r1, 3'b000, rd, 7'h33};
          3: return {im[11:5], r2, r1, 3'b100, im[4:0], 7'h63};
          4: return {7'h20, r2, r1, 3'b001, rd, 7'h13};
          default: return {im, r1, 3'b000, rd, 7'h67};
        endcase
      end
    endcase
  endfunction

  function automatic cyc_t blank();
    cyc_t c = '{default: '0};
    c.rdy = 1'($urandom);
    c.eq  = 1'($urandom);
    return c;
  endfunction

  function automatic cyc_t alu(cyc_t c, bit [1:0] a,
                               bit [1:0] b, bit [2:0] op);
    c.alu_chk = 1'b1;
    c.a  = a;
    c.b  = b;
    c.op = op;
    return c;
  endfunction

  function automatic cyc_t wb();
    cyc_t c = blank();
    c.rw      = 1'b1;
    c.res_chk = 1'b1;
    c.res     = 2'b00;
    c.done    = 1'b1;
    return c;
  endfunction

  // expected cycle list for one instruction: fetch with fw waits,
  // decode, then the class-specific phases (mw memory waits)
  task automatic model(logic [31:0] ins, bit eq, int fw, int mw);
    kind_t k = classify(ins);
    cyc_t  c;
    for (int i = 0; i <= fw; i++) begin
      c = alu(blank(), 2'b00, 2'b10, SUM_OP);
      c.fetch   = 1'b1;
      c.req     = 1'b1;
      c.res_chk = 1'b1;
      c.res     = 2'b10;
      c.rdy     = (i == fw);
      c.irw     = c.rdy;
      c.pcw     = c.rdy;
      q.push_back(c);
    end
    c = alu(blank(), 2'b01, 2'b01, SUM_OP);
    c.imm_chk = 1'b1;
    case (ins[6:0])
      7'h63:   c.imm = Branch;
      7'h6f:   c.imm = Jump;
      7'h23:   c.imm = Store;
      default: c.imm = Imm;
    endcase
    q.push_back(c);
    case (k)
      K_LW, K_SW: begin
        q.push_back(alu(blank(), 2'b10, 2'b01, SUM_OP));
        for (int i = 0; i <= mw; i++) begin
          c = blank();
          c.req  = 1'b1;
          c.adr  = 1'b1;
          c.mw   = (k == K_SW);
          c.rdy  = (i == mw);
          c.done = c.mw && c.rdy;
          q.push_back(c);
        end
        if (k == K_LW) begin
          c = blank();
          c.rw      = 1'b1;
          c.res_chk = 1'b1;
          c.res     = 2'b01;
          c.done    = 1'b1;
          q.push_back(c);
        end
      end
      K_ADD, K_SUB: begin
        q.push_back(alu(blank(), 2'b10, 2'b00,
                        (k == K_SUB) ? SUB_OP : SUM_OP));
        q.push_back(wb());
      end
      K_ADDI, K_SLLI: begin
        q.push_back(alu(blank(), 2'b10, 2'b01,
                        (k == K_SLLI) ? SLL_OP : SUM_OP));
        q.push_back(wb());
      end
      K_BEQ, K_BNE: begin
        c = alu(blank(), 2'b10, 2'b00, SUB_OP);
        c.res_chk = 1'b1;
        c.res     = 2'b00;
        c.eq      = eq;
        c.pcw     = (k == K_BEQ) ? eq : !eq;
        c.done    = 1'b1;
        q.push_back(c);
      end
      K_JAL: begin
        c = alu(blank(), 2'b01, 2'b10, SUM_OP);
        c.pcw     = 1'b1;
        c.res_chk = 1'b1;
        c.res     = 2'b00;
        q.push_back(c);
        q.push_back(wb());
      end
      default: begin
        for (int i = 0; i < 4; i++) begin
          c = blank();
          c.ill = 1'b1;
          q.push_back(c);
        end
      end
    endcase
  endtask

  // apply the modelled cycles (first cut of them when cut >= 0)
  task automatic run_instr(string tag, logic [31:0] ins, bit eq,
                           int fw, int mw, int cut);
    logic [18:0] act, exp, msk;
    int n;
    q.delete();
    model(ins, eq, fw, mw);
    n = (cut < 0) ? q.size() : cut;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      instr     = q[k].fetch ? ir_prev : ins;
      EQ        = q[k].eq;
      mem_ready = q[k].rdy;
      #1;
      act = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite,
             RegWrite, instr_done, illegal, ALUsrcA, ALUsrcB,
             3'(ALUctrl), ResultSrc, 2'(ImmSrc)};
      exp = {q[k].req, q[k].mw, q[k].adr, q[k].irw, q[k].pcw,
             q[k].rw, q[k].done, q[k].ill, q[k].a, q[k].b,
             q[k].op, q[k].res, q[k].imm};
      msk = {8'hFF, {7{q[k].alu_chk}}, {2{q[k].res_chk}},
             {2{q[k].imm_chk}}};
      vectors++;
      if ((act & msk) !== (exp & msk)) begin
        miscompares++;
        $display("FAIL %s cycle %0d instr=%h: got %b, want %b",
                 tag, k, ins, act & msk, exp & msk);
      end
`ifdef MCU_PERF_CNT_EN
      vectors++;
      if ({cycle_cnt, instret_cnt} !== {exp_cyc, exp_ret}) begin
        miscompares++;
        $display("FAIL %s_perf cycle %0d: got %0d/%0d, want %0d/%0d",
                 tag, k, cycle_cnt, instret_cnt, exp_cyc, exp_ret);
      end
`endif
      exp_cyc += q[k].ill ? 0 : 1;
      exp_ret += q[k].done ? 1 : 0;
    end
    ir_prev = ins;
  endtask

  task automatic do_reset(string tag);
    logic [18:0] act;
    @(negedge clk);
    rst       = 1'b0;
    mem_ready = 1'b1;
    EQ        = 1'b1;
    #1;
    act = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite,
           RegWrite, instr_done, illegal, ALUsrcA, ALUsrcB,
           3'(ALUctrl), ResultSrc, 2'(ImmSrc)};
    vectors++;
    if (act !== {8'h00, 2'b00, 2'b00, 3'(SUM_OP), 2'b00, 2'(Imm)})
    begin
      miscompares++;
      $display("FAIL %s: got %b, want all idle", tag, act);
    end
    repeat (2) @(posedge clk);
`ifdef MCU_PERF_CNT_EN
    vectors++;
    if ({cycle_cnt, instret_cnt} !== 64'd0) begin
      miscompares++;
      $display("FAIL %s_perf: got %0d/%0d, want 0/0",
               tag, cycle_cnt, instret_cnt);
    end
`endif
    #1 rst = 1'b1;
    exp_cyc = 0;
    exp_ret = 0;
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    instr   = '0;
    ir_prev = '0;
    do_reset("reset");
  endtask

  task automatic test_add();
    run_instr("add", 32'h002081B3, 1'b0, 0, 0, -1);
  endtask

  task automatic test_lw_wait();
    run_instr("lw_wait", 32'h00802283, 1'b0, 0, 2, -1);
  endtask

  task automatic test_bne();
    run_instr("bne_ne", 32'h00209463, 1'b0, 0, 0, -1);
    run_instr("bne_eq", 32'h00209463, 1'b1, 0, 0, -1);
  endtask

  task automatic test_jal();
    run_instr("jal", 32'h010000EF, 1'b0, 0, 0, -1);
  endtask

  task automatic test_illegal();
    run_instr("lui", 32'h123452B7, 1'b0, 1, 0, -1);
    do_reset("trap_exit");
    run_instr("post_trap", 32'h002081B3, 1'b0, 0, 0, -1);
  endtask

  task automatic test_random();
    kind_t k;
    for (int n = 0; n < 60; n++) begin
      k = kind_t'($urandom_range(0, 9));
      run_instr("rand", gen(k), 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 3), -1);
      if (k == K_ILL) do_reset("rand_trap_exit");
    end
  endtask

  task automatic test_reset_mid_write();
    // F, D, MEMADR, then two MEMWRITE wait cycles
    run_instr("sw_abort", 32'h0020A623, 1'b0, 0, 6, 5);
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({mem_req, MemWrite, AdrSrc} !== 3'b000) begin
      miscompares++;
      $display("FAIL abort: got req/mw/adr %b, want 000",
               {mem_req, MemWrite, AdrSrc});
    end
`ifdef MCU_PERF_CNT_EN
    vectors++;
    if ({cycle_cnt, instret_cnt} !== 64'd0) begin
      miscompares++;
      $display("FAIL abort_perf: got %0d/%0d, want 0/0",
               cycle_cnt, instret_cnt);
    end
`endif
    @(posedge clk);
    #1 rst = 1'b1;
    exp_cyc = 0;
    exp_ret = 0;
    run_instr("restart", 32'h402081B3, 1'b0, 1, 0, -1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_cyc     = 0;
    exp_ret     = 0;
    rst         = 1'b0;
    EQ          = 1'b0;
    mem_ready   = 1'b0;
    instr       = '0;
    test_reset();
    test_add();
    test_lw_wait();
    test_bne();
    test_jal();
    test_illegal();
    test_random();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
